// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  // Wait-state counter width; WAIT_CYCLES must fit in it (0..15).
  localparam int DMEM_WAIT_W = 4;

  // Byte-enable width for a 32-bit word.
  localparam int DMEM_BE_W = 4;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the pipeline memory stage (master) and the responder (slave).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the master holds all req_* fields stable while
// req_valid is 1 and not yet accepted. The response is a single
// resp_valid beat with no backpressure; resp_rdata/resp_err are only
// meaningful while resp_valid is 1. busy is 1 from acceptance until the
// commit cycle has ended.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [DMEM_BE_W-1:0] req_be;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;
  logic                 resp_err;
  logic                 busy;

  modport master (
    output req_valid, req_wr, req_be, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_wr, req_be, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/dmem_responder_sram_be.sv
// Single-port synchronous RAM with per-byte write enables and registered read.
// Contents have no reset.
module sram_be
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic [DMEM_BE_W-1:0] we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-masked write and read-before-write word capture on every enabled cycle.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < DMEM_BE_W; i++) begin
        if (we_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, commits in
// the RESP cycle and returns a single response beat the following cycle.
// Optional macro DMEM_ERR_CHECK_EN: flag misaligned / out-of-range requests.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output dmem_state_e       dbg_state_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_WAIT_W-1:0] WAIT_INIT = DMEM_WAIT_W'(WAIT_CYCLES);

  dmem_state_e          state_q, state_d;
  logic [DMEM_WAIT_W-1:0] cnt_q, cnt_d;

  logic                 wr_q;
  logic [DMEM_BE_W-1:0] be_q;
  logic [AW-1:0]        idx_q;
  logic [31:0]          wdata_q;
  logic                 err_q;

  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic                 rd_ok_q;

  logic                 accept;
  logic                 req_err;
  logic                 commit;
  logic                 ram_en;
  logic [DMEM_BE_W-1:0] ram_we;
  logic [31:0]          ram_rdata;
  logic                 req_ready;
  logic                 busy;

  assign accept = (state_q == IDLE) && bus.req_valid;

`ifdef DMEM_ERR_CHECK_EN
  // Misaligned, or beyond the last word of the backing store.
  assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                   ((bus.req_addr >> (AW + 2)) != 32'd0);
`else
  // Low address bits and bits above the word index are don't-care: the index wraps.
  logic unused_addr;
  assign unused_addr = ^{bus.req_addr[1:0], bus.req_addr[31:AW+2]};
  assign req_err     = 1'b0;
`endif

  // State and wait-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: count down the wait states, then spend one cycle committing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q <= DMEM_WAIT_W'(1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - DMEM_WAIT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; the RAM access lands on the edge that leaves RESP.
  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q == WAIT) || (state_q == RESP);
    commit    = (state_q == RESP) && !rst;
    ram_en    = commit && !err_q;
    ram_we    = wr_q ? be_q : '0;
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= bus.req_wr;
      be_q    <= bus.req_be;
      idx_q   <= bus.req_addr[AW+1:2];
      wdata_q <= bus.req_wdata;
      err_q   <= req_err;
    end
  end

  // One-cycle response beat following the commit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      resp_valid_q <= commit;
      resp_err_q   <= commit && err_q;
      rd_ok_q      <= commit && !wr_q && !err_q;
    end
  end

  sram_be #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign bus.req_ready  = req_ready;
  assign bus.busy       = busy;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = rd_ok_q ? ram_rdata : 32'd0;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: WAIT_CYCLES=2 instance for table vectors and reset
// corner cases, WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int W_MAIN = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if bus  ();
  dmem_responder_if bus0 ();
  dmem_state_e dbg, dbg0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W_MAIN)) u_dut (
    .clk (clk), .rst (rst), .bus (bus), .dbg_state_o (dbg)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0), .dbg_state_o (dbg0)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int resp0_cnt = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp0_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 want 0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", bus.resp_rdata, e[31:0]);
        check("resp_err", 32'(bus.resp_err), 32'(e[32]));
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (bus0.resp_valid) begin
      resp0_cnt++;
      if (exp0_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp0: got resp_valid=1 want 0 (t=%0t)", $time);
      end else begin
        e = exp0_q.pop_front();
        check("resp0_rdata", bus0.resp_rdata, e[31:0]);
        check("resp0_err", 32'(bus0.resp_err), 32'(e[32]));
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  function automatic vec_t mk(input logic wr, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd,
                              input logic exp_err);
    vec_t v;
    v.wr = wr; v.be = be; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  // Called at a negedge; returns at a negedge after the response beat.
  task automatic do_req(input vec_t v);
    int   lat;
    logic busy_ok;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wr    = v.wr;
    bus.req_be    = v.be;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(posedge clk);
    exp_q.push_back({v.exp_err, v.exp_rd});
    #1;
    bus.req_valid = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.resp_valid && lat < 50) begin
      if (!bus.busy || bus.req_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check("resp_latency", 32'(lat), 32'(W_MAIN + 1));
    check("busy_pending", 32'(busy_ok), 32'd1);
    check("ready_at_resp", 32'({bus.req_ready, bus.busy}), 32'b10);
    @(negedge clk);
  endtask

  // Store accepted, then reset hits the edge n cycles after acceptance.
  task automatic rst_mid(input logic [31:0] addr, input logic [31:0] wdata, input int n);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_be    = 4'hF;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_state", 32'(dbg), 32'(IDLE));
    check("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    repeat (6) @(negedge clk);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] w10;
    int prev_acc, acc_cyc, n;
    vec_t b2b[4];

    vt[0]  = mk(1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    vt[1]  = mk(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    vt[2]  = mk(1, 4'b0001, 32'h10, 32'h000000AA, 32'h0, 0);
    vt[3]  = mk(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEAA, 0);
    vt[4]  = mk(1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h0, 0);
    vt[5]  = mk(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEAA, 0);
    vt[6]  = mk(1, 4'hF, 32'h20, 32'h11223344, 32'h0, 0);
    vt[7]  = mk(1, 4'b1100, 32'h20, 32'hAABBCCDD, 32'h0, 0);
    vt[8]  = mk(0, 4'h0, 32'h20, 32'h0, 32'hAABB3344, 0);
    vt[9]  = mk(1, 4'hF, 32'hFFC, 32'hCAFEF00D, 32'h0, 0);
    vt[10] = mk(0, 4'h0, 32'hFFC, 32'h0, 32'hCAFEF00D, 0);
    vt[11] = mk(1, 4'hF, 32'h0, 32'h0BADF00D, 32'h0, 0);
`ifdef DMEM_ERR_CHECK_EN
    vt[12] = mk(0, 4'h0, 32'h1002, 32'h0, 32'h0, 1);
    vt[13] = mk(1, 4'hF, 32'h1000, 32'h00000055, 32'h0, 1);
    vt[14] = mk(0, 4'h0, 32'h0, 32'h0, 32'h0BADF00D, 0);
    vt[15] = mk(1, 4'b0010, 32'h11, 32'h0000EE00, 32'h0, 1);
    vt[16] = mk(0, 4'h0, 32'h10, 32'h0, 32'hDEADBEAA, 0);
`else
    vt[12] = mk(0, 4'h0, 32'h1002, 32'h0, 32'h0BADF00D, 0);
    vt[13] = mk(1, 4'hF, 32'h1000, 32'h00000055, 32'h0, 0);
    vt[14] = mk(0, 4'h0, 32'h0, 32'h0, 32'h00000055, 0);
    vt[15] = mk(1, 4'b0010, 32'h11, 32'h0000EE00, 32'h0, 0);
    vt[16] = mk(0, 4'h0, 32'h10, 32'h0, 32'hDEADEEAA, 0);
`endif
    w10 = vt[16].exp_rd;

    b2b[0] = mk(1, 4'hF, 32'h0, 32'h11111111, 32'h0, 0);
    b2b[1] = mk(0, 4'h0, 32'h0, 32'h0, 32'h11111111, 0);
    b2b[2] = mk(1, 4'hF, 32'h4, 32'h22222222, 32'h0, 0);
    b2b[3] = mk(0, 4'h0, 32'h4, 32'h0, 32'h22222222, 0);

    // Reset with a store held valid on both instances.
    bus.req_valid  = 1'b1; bus.req_wr  = 1'b1; bus.req_be  = 4'hF;
    bus.req_addr   = 32'h0; bus.req_wdata = 32'hFFFFFFFF;
    bus0.req_valid = 1'b1; bus0.req_wr = 1'b1; bus0.req_be = 4'hF;
    bus0.req_addr  = 32'h0; bus0.req_wdata = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid  = 1'b0;
    bus0.req_valid = 1'b0;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(dbg), 32'(IDLE));

    // Table vectors.
    for (int i = 0; i < NV; i++) do_req(vt[i]);

    // Reset held with a store pending: memory must stay untouched.
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_be = 4'hF;
    bus.req_addr  = 32'h10; bus.req_wdata = 32'h5A5A5A5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    do_req(mk(0, 4'h0, 32'h10, 32'h0, w10, 0));

    // Reset during WAIT and on the commit edge: store must not land.
    rst_mid(32'h20, 32'h99999999, 1);
    do_req(mk(0, 4'h0, 32'h20, 32'h0, 32'hAABB3344, 0));
    rst_mid(32'h20, 32'h77777777, 3);
    do_req(mk(0, 4'h0, 32'h20, 32'h0, 32'hAABB3344, 0));

    // Back-to-back on the zero-wait instance with req_valid held.
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      bus0.req_valid = 1'b1;
      bus0.req_wr    = b2b[i].wr;
      bus0.req_be    = b2b[i].be;
      bus0.req_addr  = b2b[i].addr;
      bus0.req_wdata = b2b[i].wdata;
      n = 0;
      while (!bus0.req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("b2b_ready_timeout", 32'(bus0.req_ready), 32'd1);
      acc_cyc = cyc;
      if (i > 0) check("b2b_gap", 32'(acc_cyc - prev_acc), 32'd2);
      prev_acc = acc_cyc;
      @(posedge clk);
      exp0_q.push_back({b2b[i].exp_err, b2b[i].exp_rd});
      #1;
      check("b2b_busy", 32'({bus0.busy, bus0.req_ready}), 32'b10);
    end
    bus0.req_valid = 1'b0;

    repeat (6) @(negedge clk);
    check("b2b_resp_count", 32'(resp0_cnt), 32'd4);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp0_q_empty", 32'(exp0_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "time limit");
  end

endmodule
